microwave_cook_controller: RTL
==============================

Name: microwave_cook_controller

Overview:
- Control FSM that sits directly downstream of the minutes/seconds countdown timer.
- Consumes the timer's three BCD digits, detects zero, and gates the timer count enable.
- Drives magnetron_on and a done beep from start, stop_clear and door inputs.
- Also issues a one-cycle clear pulse back to the timer.

Parameters:
- BEEP_CYCLES, 20, number of CLK cycles done_beep stays asserted in DONE; must be >= 1.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset (Reset=0 sampled on a CLK rising edge resets the block).
- start  input  1  start/resume button, level; acted on at rising edge only.
- stop_clear  input  1  stop/clear button, level; acted on at rising edge only.
- door_closed  input  1  1 = door closed.
- seconds_units  input  4  BCD from timer.
- seconds_tens  input  4  BCD from timer.
- minutes_units  input  4  BCD from timer.
- timer_enable  output  1  count enable to timer.
- timer_clear  output  1  one-cycle pulse; timer zeroes its digits.
- magnetron_on  output  1  heating element drive.
- done_beep  output  1  buzzer drive.
- state  output  2  current state, for display/debug.

Behaviour:
- States: IDLE=0, COOKING=1, PAUSED=2, DONE=3.
- Reset (Reset=0 at edge):
  - state=IDLE, timer_clear=0, beep counter=0.
  - start_prev=1 and stop_prev=1, so a button held through reset does not fire.
- Edge detect:
  - start_rise = start & ~start_prev; stop_rise likewise.
  - prev registers update every cycle.
  - Event sampled at edge N gives new state visible after edge N (one-cycle latency).
- time_zero = all three digits == 0. Digit values >9 count as nonzero.
- IDLE:
  - start_rise & door_closed & ~time_zero -> COOKING.
  - start_rise with door open or time_zero -> stay IDLE.
  - stop_rise -> stay IDLE, pulse timer_clear.
- COOKING, priority top down:
  - time_zero -> DONE.
  - ~door_closed -> PAUSED.
  - stop_rise -> PAUSED.
  - otherwise stay.
- PAUSED:
  - stop_rise -> IDLE, pulse timer_clear (stop beats start if both rise together).
  - start_rise & door_closed -> COOKING.
  - otherwise stay. Timer digits are held, not cleared.
- DONE:
  - Beep counter loads 0 on entry and increments each cycle.
  - -> IDLE when counter == BEEP_CYCLES-1 or on stop_rise.
  - start_rise ignored.
  - No timer_clear (timer is already zero).
- Outputs:
  - timer_enable = (state==COOKING) & door_closed. Combinational gate so an open door stops counting and heating in the same cycle.
  - magnetron_on = (state==COOKING) & door_closed.
  - done_beep = (state==DONE).
  - timer_clear is a registered one-cycle pulse, asserted the cycle after the stop_rise edge.
- Reset mid-cook: IDLE next edge, all outputs 0. The timer is reset by its own reset.
- Beep counter width = $clog2(BEEP_CYCLES+1).

Decomposition:
- Shared package microwave_pkg:
  - state encoding constants ST_IDLE/ST_COOKING/ST_PAUSED/ST_DONE, 2 bits.
  - BCD digit width constant (4).
- One sub-module: rising_edge_detect (CLK, Reset, in, rise), with prev register resetting to 1. Instantiated for start and stop_clear.

Test Plan:
- Reset low 2 cycles, then high; digits 0:3:0, door_closed=1, pulse start → state=1 one cycle after the start edge; timer_enable=1 and magnetron_on=1.
- Cooking with digits forced to 0:0:0 → state=3, done_beep=1 for exactly 20 cycles, then state=0 and all outputs 0.
- In COOKING drop door_closed → timer_enable and magnetron_on =0 the same cycle, state=2 the next cycle. Close door and pulse start → state=1.
- In PAUSED pulse stop_clear → state=0 and timer_clear high exactly 1 cycle. Pulse start with digits 0:0:0 → stays 0.
- Hold start=1 across reset release → no transition to COOKING. start and stop_clear rising together in PAUSED → IDLE.
- Assert Reset=0 mid-COOKING → state=0, timer_enable=0, magnetron_on=0 after that edge. Asserting Reset=0 between edges has no effect until the next edge.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared encodings for the microwave cook controller: FSM state values and timer digit width.
package microwave_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// One-cycle rising-edge detector for a level button input.
module rising_edge_detect (
    input  logic CLK,
    input  logic Reset,
    input  logic in,
    output logic rise
);

    logic prev;

    // prev comes out of reset high so a button held through reset never fires.
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            prev <= 1'b1;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/microwave_cook_controller.sv
// Cook-cycle FSM downstream of the BCD countdown timer: gates counting and heating, beeps when done.
module microwave_cook_controller
    import microwave_pkg::*;
#(
    parameter int BEEP_CYCLES = 20
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             stop_clear,
    input  logic             door_closed,
    input  logic [BCD_W-1:0] seconds_units,
    input  logic [BCD_W-1:0] seconds_tens,
    input  logic [BCD_W-1:0] minutes_units,
    output logic             timer_enable,
    output logic             timer_clear,
    output logic             magnetron_on,
    output logic             done_beep,
    output logic [1:0]       state
);

    localparam int                CNT_W     = $clog2(BEEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] beep_cnt;
    logic             clear_d;
    logic             timer_clear_q;
    logic             start_rise;
    logic             stop_rise;
    logic             time_zero;
    logic             heating;

    rising_edge_detect u_start_edge (
        .CLK   (CLK),
        .Reset (Reset),
        .in    (start),
        .rise  (start_rise)
    );

    rising_edge_detect u_stop_edge (
        .CLK   (CLK),
        .Reset (Reset),
        .in    (stop_clear),
        .rise  (stop_rise)
    );

    // Out-of-range digit codes are nonzero, so only a true 0:00 ends the cook.
    assign time_zero = (seconds_units == '0) && (seconds_tens == '0) && (minutes_units == '0);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A stop press wins over a simultaneous start and clears the timer.
                if (stop_rise) begin
                    clear_d = 1'b1;
                end else if (start_rise && door_closed && !time_zero) begin
                    state_d = ST_COOKING;
                end
            end
            ST_COOKING: begin
                if (time_zero) begin
                    state_d = ST_DONE;
                end else if (!door_closed || stop_rise) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (stop_rise) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end else if (start_rise && door_closed) begin
                    state_d = ST_COOKING;
                end
            end
            ST_DONE: begin
                if (stop_rise || beep_cnt == BEEP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            beep_cnt      <= '0;
            timer_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            // Held at zero outside DONE, so it reads zero on the first DONE cycle.
            beep_cnt      <= (state_q == ST_DONE) ? beep_cnt + CNT_W'(1) : '0;
            timer_clear_q <= clear_d;
        end
    end

    // Door gating is combinational so opening the door kills heat within the same cycle.
    assign heating      = (state_q == ST_COOKING) && door_closed;
    assign timer_enable = heating;
    assign magnetron_on = heating;
    assign done_beep    = (state_q == ST_DONE);
    assign timer_clear  = timer_clear_q;
    assign state        = state_q;

endmodule
